block_mem_responder: RTL and testbench

//  Backing-store responder for the direct-mapped cache's miss path: fills and write-backs of whole blocks.

---
 rtl/block_mem_responder.sv | 125 ++++++++++++
 tb/tb_block_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_mem_responder.sv
// Block-granular backing store for the cache miss path: accepts one block request,
// waits a fixed latency, commits a write or returns a read block, then pulses block_valid.
module block_mem_responder #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3,
    parameter int LATENCY            = 4
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          req,
    input  logic                                          we,
    input  logic [ADDR_WIDTH-1:0]                         addr,
    input  logic [DATA_WIDTH*(1<<BLOCK_OFFSET_WIDTH)-1:0] block_din,
    output logic [DATA_WIDTH*(1<<BLOCK_OFFSET_WIDTH)-1:0] block_dout,
    output logic                                          block_valid,
    output logic                                          busy,
    input  logic [ADDR_WIDTH-1:0]                         debug_addr,
    output logic [DATA_WIDTH-1:0]                         debug_dout
);

    localparam int BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
    localparam int BLOCK_BITS = DATA_WIDTH * BLOCK_SIZE;
    localparam int IDX_W      = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q;
    logic                    we_q;
    logic [BLOCK_BITS-1:0]   din_q;
    logic [BLOCK_BITS-1:0]   dout_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    accept;
    logic                    commit;
    logic [BLOCK_BITS-1:0]   rd_block;

    logic [DATA_WIDTH-1:0]   mem [1<<ADDR_WIDTH];

    // The word offset inside a block is irrelevant: every transfer is a whole block.
    logic unused_offset;
    assign unused_offset = ^addr[BLOCK_OFFSET_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_block = '0;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            rd_block[k*DATA_WIDTH +: DATA_WIDTH] = mem[{idx_q, BLOCK_OFFSET_WIDTH'(k)}];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == S_RESP);
            busy_q  <= (state_d != S_IDLE);
            if (accept) begin
                idx_q <= addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
                we_q  <= we;
                din_q <= block_din;
            end
            if (commit) begin
                dout_q <= we_q ? din_q : rd_block;
            end
        end
    end

    // Storage has no reset; commit is only raised out of WAIT, so a reset aborts any pending write.
    always_ff @(posedge clk) begin
        if (commit && we_q) begin
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                mem[{idx_q, BLOCK_OFFSET_WIDTH'(k)}] <= din_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign block_dout  = dout_q;
    assign block_valid = valid_q;
    assign busy        = busy_q;
    assign debug_dout  = mem[debug_addr];

endmodule

// File: tb/tb_block_mem_responder.sv
// Bench for block_mem_responder: three instances (latency 4, 2, 7) driven by directed and
// random block transactions, checked against a word-array model of each backing store.
module tb_block_mem_responder;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int BOW = 3;
    localparam int BS  = 1 << BOW;
    localparam int BW  = DW * BS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          req4, req2, req7;
    logic          we;
    logic [AW-1:0] addr, debugAddr;
    logic [BW-1:0] din;
    logic [BW-1:0] dout4, dout2, dout7;
    logic          valid4, valid2, valid7;
    logic          busy4, busy2, busy7;
    logic [DW-1:0] dbg4, dbg2, dbg7;

    block_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(BOW), .LATENCY(4)) dut4 (
        .clk(clk), .rstn(rstn), .req(req4), .we(we), .addr(addr), .block_din(din),
        .block_dout(dout4), .block_valid(valid4), .busy(busy4),
        .debug_addr(debugAddr), .debug_dout(dbg4));

    block_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(BOW), .LATENCY(2)) dut2 (
        .clk(clk), .rstn(rstn), .req(req2), .we(we), .addr(addr), .block_din(din),
        .block_dout(dout2), .block_valid(valid2), .busy(busy2),
        .debug_addr(debugAddr), .debug_dout(dbg2));

    block_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(BOW), .LATENCY(7)) dut7 (
        .clk(clk), .rstn(rstn), .req(req7), .we(we), .addr(addr), .block_din(din),
        .block_dout(dout7), .block_valid(valid7), .busy(busy7),
        .debug_addr(debugAddr), .debug_dout(dbg7));

    int checks = 0;
    int errors = 0;

    // The selector value doubles as the latency of the chosen instance.
    int            selDut = 4;
    logic          selValid, selBusy;
    logic [BW-1:0] selDout;
    logic [DW-1:0] selDbg;

    always_comb begin
        case (selDut)
            2:       begin selValid = valid2; selBusy = busy2; selDout = dout2; selDbg = dbg2; end
            7:       begin selValid = valid7; selBusy = busy7; selDout = dout7; selDbg = dbg7; end
            default: begin selValid = valid4; selBusy = busy4; selDout = dout4; selDbg = dbg4; end
        endcase
    end

    logic [DW-1:0] modelMem [3][1 << AW];
    bit            known    [3][1 << AW];

    function automatic int slot(int sel);
        return (sel == 2) ? 1 : (sel == 7) ? 2 : 0;
    endfunction

    function automatic int blockBase(logic [AW-1:0] a);
        return (int'(a) / BS) * BS;
    endfunction

    function automatic logic [BW-1:0] modelRead(int sel, logic [AW-1:0] a);
        logic [BW-1:0] r;
        for (int k = 0; k < BS; k++) r[k*DW +: DW] = modelMem[slot(sel)][blockBase(a) + k];
        return r;
    endfunction

    function automatic void modelWrite(int sel, logic [AW-1:0] a, logic [BW-1:0] d);
        for (int k = 0; k < BS; k++) begin
            modelMem[slot(sel)][blockBase(a) + k] = d[k*DW +: DW];
            known[slot(sel)][blockBase(a) + k]    = 1'b1;
        end
    endfunction

    function automatic logic [BW-1:0] randBlock();
        logic [BW-1:0] r;
        for (int k = 0; k < BS; k++) r[k*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int sel, input logic v);
        case (sel)
            2:       req2 = v;
            7:       req7 = v;
            default: req4 = v;
        endcase
    endtask

    // One full transaction: accept, then watch every cycle up to and past the completion pulse.
    task automatic applyStimulus(input int sel, input bit w, input logic [AW-1:0] a,
                                 input logic [BW-1:0] d, input bit scramble, input bit dbgCheck);
        int            lat;
        logic [BW-1:0] expBlk;
        logic [AW-1:0] dbgA;
        logic [DW-1:0] oldW, newW;
        lat    = sel;
        selDut = sel;
        dbgA   = {a[AW-1:BOW], 3'd3};
        expBlk = w ? d : modelRead(sel, a);
        oldW   = modelMem[slot(sel)][dbgA];
        newW   = w ? d[3*DW +: DW] : oldW;
        @(negedge clk);
        setReq(sel, 1'b1);
        we = w; addr = a; din = d; debugAddr = dbgA;
        @(posedge clk);
        #1;
        setReq(sel, 1'b0);
        if (w) modelWrite(sel, a, d);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            checkOutput("busy_inflight", selBusy, 1'b1);
            checkOutput("valid_timing", selValid, c == lat);
            if (dbgCheck && c == lat - 1) checkOutput("debug_before_commit", selDbg, oldW);
            if (dbgCheck && c == lat)     checkOutput("debug_after_commit", selDbg, newW);
            if (c == lat) checkOutput("block_dout", selDout, expBlk);
            if (scramble) begin
                we   = 1'($urandom);
                addr = AW'($urandom);
                din  = randBlock();
            end
        end
        @(negedge clk);
        checkOutput("valid_after_resp", selValid, 1'b0);
        checkOutput("busy_after_resp", selBusy, 1'b0);
        checkOutput("dout_hold", selDout, expBlk);
    endtask

    // req held high: a new read is accepted every LATENCY+1 cycles.
    task automatic heldRun(input int sel, input logic [AW-1:0] a, input int nTxn);
        int            lat, period, n;
        logic [BW-1:0] expBlk;
        logic          prev;
        lat    = sel;
        period = lat + 1;
        n      = nTxn * period;
        expBlk = modelRead(sel, a);
        prev   = 1'b0;
        selDut = sel;
        @(negedge clk);
        we = 1'b0; addr = a;
        setReq(sel, 1'b1);
        @(posedge clk);
        #1;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            checkOutput("held_valid", selValid, (j % period) == lat);
            checkOutput("held_no_consecutive", prev & selValid, 1'b0);
            prev = selValid;
            if ((j % period) == lat) checkOutput("held_dout", selDout, expBlk);
            if (j == n - 1) setReq(sel, 1'b0);
        end
        checkOutput("held_idle_busy", selBusy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BW-1:0] blk;
        logic [BW-1:0] oldBlk;
        int            sel;
        logic [AW-1:0] a;
        bit            w, wasKnown;

        rstn = 1'b0; req4 = 1'b0; req2 = 1'b0; req7 = 1'b0;
        we = 1'b0; addr = '0; din = '0; debugAddr = '0;
        foreach (known[i, j]) known[i][j] = 1'b0;

        for (int s = 0; s < 3; s++) begin
            selDut = (s == 0) ? 4 : (s == 1) ? 2 : 7;
            #1;
            checkOutput("reset_valid", selValid, 1'b0);
            checkOutput("reset_busy", selBusy, 1'b0);
            checkOutput("reset_dout", selDout, '0);
        end
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] preload and block read");
        for (int k = 0; k < BS; k++) blk[k*DW +: DW] = DW'(16 + k);
        applyStimulus(4, 1'b1, 10'h010, blk, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 10'h013, randBlock(), 1'b0, 1'b0);

        $display("[TB] write then read top block, debug port");
        applyStimulus(4, 1'b1, 10'h3F8, randBlock(), 1'b0, 1'b0);
        for (int k = 0; k < BS; k++) blk[k*DW +: DW] = DW'(32'hA0 + k);
        applyStimulus(4, 1'b1, 10'h3F8, blk, 1'b0, 1'b1);
        applyStimulus(4, 1'b0, 10'h3FD, randBlock(), 1'b0, 1'b1);

        $display("[TB] inputs change during WAIT");
        applyStimulus(4, 1'b1, 10'h100, randBlock(), 1'b1, 1'b0);
        applyStimulus(4, 1'b0, 10'h105, randBlock(), 1'b1, 1'b1);

        $display("[TB] req held high");
        heldRun(4, 10'h3F8, 3);

        $display("[TB] reset during a write");
        selDut = 4;
        oldBlk = modelRead(4, 10'h3F8);
        @(negedge clk);
        req4 = 1'b1; we = 1'b1; addr = 10'h3F8; din = randBlock();
        @(posedge clk);
        #1;
        req4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("abort_valid", selValid, 1'b0);
        checkOutput("abort_busy", selBusy, 1'b0);
        checkOutput("abort_dout", selDout, '0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < BS; k++) begin
            debugAddr = AW'(10'h3F8 + k);
            #1;
            checkOutput("abort_storage", selDbg, oldBlk[k*DW +: DW]);
        end
        applyStimulus(4, 1'b0, 10'h3F8, randBlock(), 1'b0, 1'b1);

        $display("[TB] latency 2 and 7");
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0) ? 2 : 7;
            applyStimulus(sel, 1'b1, 10'h040, randBlock(), 1'b0, 1'b0);
            applyStimulus(sel, 1'b1, 10'h040, randBlock(), 1'b1, 1'b1);
            applyStimulus(sel, 1'b0, 10'h047, randBlock(), 1'b0, 1'b1);
            heldRun(sel, 10'h040, 2);
        end

        $display("[TB] random transactions");
        for (int i = 0; i < 30; i++) begin
            sel      = ($urandom_range(0, 2) == 0) ? 4 : ($urandom_range(0, 1) == 0) ? 2 : 7;
            a        = AW'($urandom_range(0, (1 << AW) - 1));
            wasKnown = known[slot(sel)][blockBase(a)];
            w        = !wasKnown || ($urandom_range(0, 1) == 1);
            applyStimulus(sel, w, a, randBlock(), 1'($urandom_range(0, 1)), wasKnown);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
